// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback arbiter and register scoreboard for the RV32I core.
//
// Two writeback requesters (0 = execute, 1 = load unit) share the register
// file's single write port. One requester is accepted per cycle, with
// round-robin priority. The accepted write goes through one registered
// output stage (WEn/rd/rdv). A per-register busy bit tracks writes that have
// been issued but not yet written, so Decode can stall on those operands.
//
// Ports:
//   clk        clock; all state updates on posedge
//   rst        synchronous active-high reset
//   req_valid  per-requester write pending
//   req_ready  per-requester accept (combinational, at most one bit set)
//   req_rd     per-requester destination index, slice i = requester i
//   req_data   per-requester write data, slice i = requester i
//   iss_valid  Decode issues an instruction that writes a register
//   iss_rd     destination of the issued instruction
//   WEn        register-file write enable (registered)
//   rd         register-file destination index (registered)
//   rdv        register-file write data (registered)
//   busy       bit r set while a write to register r is outstanding
//   waw_err    sticky: an issue targeted a register that was still busy
module wb_arbiter #(
  parameter int unsigned data_width = 32,
  parameter int unsigned num_reg    = 32,
  parameter int unsigned idx_width  = $clog2(num_reg),
  parameter int unsigned num_req    = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [num_req-1:0]              req_valid,
  output logic [num_req-1:0]              req_ready,
  input  logic [num_req*idx_width-1:0]    req_rd,
  input  logic [num_req*data_width-1:0]   req_data,
  input  logic                            iss_valid,
  input  logic [idx_width-1:0]            iss_rd,
  output logic                            WEn,
  output logic [idx_width-1:0]            rd,
  output logic [data_width-1:0]           rdv,
  output logic [num_reg-1:0]              busy,
  output logic                            waw_err
);

  localparam int unsigned GntWidth = (num_req > 1) ? $clog2(num_req) : 1;

  // State
  logic [GntWidth-1:0]   last_grant_q, last_grant_d;
  logic                  wen_q, wen_d;
  logic [idx_width-1:0]  rd_q, rd_d;
  logic [data_width-1:0] rdv_q, rdv_d;
  logic [num_reg-1:0]    busy_q, busy_d;
  logic                  waw_err_q, waw_err_d;

  // Arbitration results
  logic                  gnt_valid;
  logic [GntWidth-1:0]   gnt_idx;
  logic [GntWidth-1:0]   cand_idx;
  int unsigned           cand;
  logic [idx_width-1:0]  sel_rd;
  logic [data_width-1:0] sel_data;

  // Scoreboard helpers
  logic iss_set;
  logic rd_clearing;
  logic waw_hit;

  // Round-robin search starting one past the last accepted requester. Held
  // off entirely during reset so no requester sees a ready it could consume.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    cand_idx  = '0;
    if (!rst) begin
      for (int unsigned k = 1; k <= num_req; k++) begin
        cand     = (32'(last_grant_q) + k) % num_req;
        cand_idx = cand[GntWidth-1:0];
        if (!gnt_valid && req_valid[cand_idx]) begin
          gnt_valid = 1'b1;
          gnt_idx   = cand_idx;
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (gnt_valid) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  // Slices belonging to the winner
  always_comb begin
    sel_rd   = req_rd[32'(gnt_idx)*idx_width +: idx_width];
    sel_data = req_data[32'(gnt_idx)*data_width +: data_width];
  end

  // Output stage: an accept always loads rd/rdv, but x0 never raises WEn.
  always_comb begin
    last_grant_d = last_grant_q;
    wen_d        = 1'b0;
    rd_d         = rd_q;
    rdv_d        = rdv_q;
    if (gnt_valid) begin
      last_grant_d = gnt_idx;
      wen_d        = (sel_rd != '0);
      rd_d         = sel_rd;
      rdv_d        = sel_data;
    end
  end

  // Scoreboard. Clear happens on the edge where the register file captures
  // the write; a same-cycle issue to that register wins and keeps it busy.
  always_comb begin
    iss_set     = iss_valid && (iss_rd != '0);
    rd_clearing = wen_q && (rd_q != '0);
    waw_hit     = iss_set && busy_q[iss_rd] && !(rd_clearing && (rd_q == iss_rd));

    busy_d = busy_q;
    if (rd_clearing) begin
      busy_d[rd_q] = 1'b0;
    end
    if (iss_set) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;

    waw_err_d = waw_err_q | waw_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= GntWidth'(num_req - 1);
      wen_q        <= 1'b0;
      rd_q         <= '0;
      rdv_q        <= '0;
      busy_q       <= '0;
      waw_err_q    <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      wen_q        <= wen_d;
      rd_q         <= rd_d;
      rdv_q        <= rdv_d;
      busy_q       <= busy_d;
      waw_err_q    <= waw_err_d;
    end
  end

  assign WEn     = wen_q;
  assign rd      = rd_q;
  assign rdv     = rdv_q;
  assign busy    = busy_q;
  assign waw_err = waw_err_q;

  // Structural sanity: a single winner, and only a valid requester can win.
  assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
  assert property (@(posedge clk) disable iff (rst) (req_ready & ~req_valid) == '0);
  assert property (@(posedge clk) busy[0] == 1'b0);

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter. Inputs are driven 1 ns after each
// rising edge and outputs are checked before the next one.
module tb_wb_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [9:0]  req_rd;
  logic [63:0] req_data;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        wen;
  logic [4:0]  rd;
  logic [31:0] rdv;
  logic [31:0] busy;
  logic        waw_err;

  int n_checks = 0;
  int n_errors = 0;

  wb_arbiter #(
    .data_width(32),
    .num_reg   (32),
    .idx_width (5),
    .num_req   (2)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_rd   (req_rd),
    .req_data (req_data),
    .iss_valid(iss_valid),
    .iss_rd   (iss_rd),
    .WEn      (wen),
    .rd       (rd),
    .rdv      (rdv),
    .busy     (busy),
    .waw_err  (waw_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [1:0] v, input logic [4:0] rd0, input logic [31:0] d0,
                         input logic [4:0] rd1, input logic [31:0] d1);
    req_valid = v;
    req_rd    = {rd1, rd0};
    req_data  = {d1, d0};
  endtask

  initial begin
    rst       = 1'b1;
    iss_valid = 1'b0;
    iss_rd    = '0;
    set_req(2'b11, 5'd1, 32'h1, 5'd2, 32'h2);

    // Reset: no ready while rst is high
    #1;
    check("rst_ready", 32'(req_ready), 32'h0);
    tick();
    check("rst_ready2", 32'(req_ready), 32'h0);
    tick();
    rst = 1'b0;
    req_valid = 2'b00;
    #1;
    check("rst_wen", 32'(wen), 32'h0);
    check("rst_busy", busy, 32'h0);
    check("rst_waw", 32'(waw_err), 32'h0);
    check("rst_rd", 32'(rd), 32'h0);
    check("rst_rdv", rdv, 32'h0);

    // Contention: grants alternate 0,1,0,1
    set_req(2'b11, 5'd5, 32'hAAAA_0001, 5'd6, 32'hBBBB_0002);
    #1;
    check("cont_gnt0", 32'(req_ready), 32'h1);
    tick();
    check("cont_gnt1", 32'(req_ready), 32'h2);
    check("cont_wen1", 32'(wen), 32'h1);
    check("cont_rd1", 32'(rd), 32'd5);
    check("cont_rdv1", rdv, 32'hAAAA_0001);
    tick();
    check("cont_gnt2", 32'(req_ready), 32'h1);
    check("cont_wen2", 32'(wen), 32'h1);
    check("cont_rd2", 32'(rd), 32'd6);
    check("cont_rdv2", rdv, 32'hBBBB_0002);
    tick();
    check("cont_gnt3", 32'(req_ready), 32'h2);
    check("cont_rd3", 32'(rd), 32'd5);
    tick();
    req_valid = 2'b00;
    #1;
    check("cont_ready_idle", 32'(req_ready), 32'h0);
    check("cont_wen4", 32'(wen), 32'h1);
    check("cont_rd4", 32'(rd), 32'd6);
    tick();
    check("idle_wen", 32'(wen), 32'h0);
    check("idle_rd_hold", 32'(rd), 32'd6);

    // x0 write: accepted but no write enable
    set_req(2'b10, 5'd0, 32'h0, 5'd0, 32'hDEAD_BEEF);
    #1;
    check("x0_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 2'b00;
    #1;
    check("x0_wen", 32'(wen), 32'h0);
    check("x0_busy", busy, 32'h0);

    // Scoreboard round trip on r10
    iss_valid = 1'b1;
    iss_rd    = 5'd10;
    tick();
    iss_valid = 1'b0;
    #1;
    check("sb_set", busy, 32'h0000_0400);
    tick();
    tick();
    set_req(2'b01, 5'd10, 32'h1234_5678, 5'd0, 32'h0);
    #1;
    check("sb_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
    #1;
    check("sb_wen", 32'(wen), 32'h1);
    check("sb_rd", 32'(rd), 32'd10);
    check("sb_rdv", rdv, 32'h1234_5678);
    check("sb_busy_wr", busy, 32'h0000_0400);
    tick();
    check("sb_clear", busy, 32'h0);
    check("sb_wen_off", 32'(wen), 32'h0);

    // Same-cycle set and clear on r7, then a true WAW issue
    iss_valid = 1'b1;
    iss_rd    = 5'd7;
    tick();
    iss_valid = 1'b0;
    set_req(2'b01, 5'd7, 32'h0000_0077, 5'd0, 32'h0);
    #1;
    check("sc_busy", busy, 32'h0000_0080);
    check("sc_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
    iss_valid = 1'b1;
    iss_rd    = 5'd7;
    #1;
    check("sc_wen", 32'(wen), 32'h1);
    check("sc_rd", 32'(rd), 32'd7);
    tick();
    // r7 busy and not clearing: this issue is a WAW violation
    #1;
    check("sc_busy_kept", busy, 32'h0000_0080);
    check("sc_waw_clear", 32'(waw_err), 32'h0);
    tick();
    iss_valid = 1'b0;
    #1;
    check("waw_set", 32'(waw_err), 32'h1);
    check("waw_busy", busy, 32'h0000_0080);
    tick();
    check("waw_sticky", 32'(waw_err), 32'h1);

    // Reset mid-flight: write to r3 in the output stage when rst arrives
    iss_valid = 1'b1;
    iss_rd    = 5'd3;
    tick();
    iss_valid = 1'b0;
    set_req(2'b01, 5'd3, 32'h3333_3333, 5'd0, 32'h0);
    #1;
    check("mf_busy", busy, 32'h0000_0088);
    check("mf_ready", 32'(req_ready), 32'h1);
    tick();
    rst = 1'b1;
    req_valid = 2'b00;
    #1;
    check("mf_ready_rst", 32'(req_ready), 32'h0);
    tick();
    rst = 1'b0;
    #1;
    check("mf_wen", 32'(wen), 32'h0);
    check("mf_busy_clr", busy, 32'h0);
    check("mf_waw_clr", 32'(waw_err), 32'h0);

    // Priority restarts at requester 0 after reset
    set_req(2'b11, 5'd1, 32'h1, 5'd2, 32'h2);
    #1;
    check("post_rst_gnt", 32'(req_ready), 32'h1);
    tick();
    req_valid = 2'b00;
    #1;
    check("post_rst_rd", 32'(rd), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
